// File: rtl/sc_regbank_multimode.sv
// -----------------------------------------------------------------------------
// sc_regbank_multimode
//   Register file for the microdatapath. It holds REGS registers, each
//   DATAWIDTH bits wide. There is one write port, which can load, increment,
//   shift left by one or logically shift right by one. There are also two
//   independent registered read ports, which feed the ALU operand buses.
//
// Optional feature (compile-time macro):
//   SC_REGBANK_BYPASS_EN - when defined, a read port that selects the register
//   being written on the same edge captures the new value. When undefined, it
//   captures the old value, and the new value is visible one cycle later.
//
// Ports:
//   SC_RegGENERAL_CLOCK_50      clock, rising edge
//   SC_RegGENERAL_RESET_InHigh  asynchronous reset, active-high
//   clear_InLow                 synchronous clear of the whole bank, active-low
//   load_InLow                  write-port enable, active-low
//   mode_In                     00 load, 01 increment, 10 shl1, 11 shr1
//   wr_addr_In                  write-port register select
//   data_InBUS                  write data (load mode only)
//   rdA_addr_In / rdB_addr_In   read-port selects
//   rdA_data_OutBUS / rdB_...   registered read data, latency 1
//   carry_Out                   carry or shift-out of the last executed write
//   zero_Out                    result of the last executed write was zero
// -----------------------------------------------------------------------------
module sc_regbank_multimode #(
  parameter int DATAWIDTH = 32,
  parameter int REGS      = 8,
  parameter int ADDRWIDTH = 3
) (
  input  logic                 SC_RegGENERAL_CLOCK_50,
  input  logic                 SC_RegGENERAL_RESET_InHigh,
  input  logic                 clear_InLow,
  input  logic                 load_InLow,
  input  logic [1:0]           mode_In,
  input  logic [ADDRWIDTH-1:0] wr_addr_In,
  input  logic [DATAWIDTH-1:0] data_InBUS,
  input  logic [ADDRWIDTH-1:0] rdA_addr_In,
  input  logic [ADDRWIDTH-1:0] rdB_addr_In,
  output logic [DATAWIDTH-1:0] rdA_data_OutBUS,
  output logic [DATAWIDTH-1:0] rdB_data_OutBUS,
  output logic                 carry_Out,
  output logic                 zero_Out
);

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_e;

  logic [DATAWIDTH-1:0] regs [REGS];

  logic                 wr_en;
  logic [DATAWIDTH-1:0] old_val;
  logic [DATAWIDTH-1:0] new_val;
  logic                 new_carry;
  logic [DATAWIDTH-1:0] rd_a_next;
  logic [DATAWIDTH-1:0] rd_b_next;

  // Address decode covers banks whose size is not a power of two.
  function automatic logic in_range(input logic [ADDRWIDTH-1:0] addr);
    return 32'(addr) < REGS;
  endfunction

  // Write-port datapath and read-port selection.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    wr_en     = !load_InLow && in_range(wr_addr_In);
    old_val   = '0;
    new_val   = '0;
    new_carry = 1'b0;
    rd_a_next = '0;
    rd_b_next = '0;

    if (in_range(wr_addr_In)) old_val = regs[wr_addr_In];

    unique case (mode_e'(mode_In))
      MODE_LOAD: new_val = data_InBUS;
      MODE_INC:  {new_carry, new_val} = {1'b0, old_val} + (DATAWIDTH+1)'(1);
      MODE_SHL:  {new_carry, new_val} = {old_val, 1'b0};
      MODE_SHR:  {new_val, new_carry} = {1'b0, old_val};
    endcase

    if (in_range(rdA_addr_In)) rd_a_next = regs[rdA_addr_In];
    if (in_range(rdB_addr_In)) rd_b_next = regs[rdB_addr_In];

`ifdef SC_REGBANK_BYPASS_EN
    // A read that selects the register being written sees the new value.
    if (wr_en && rdA_addr_In == wr_addr_In) rd_a_next = new_val;
    if (wr_en && rdB_addr_In == wr_addr_In) rd_b_next = new_val;
`else
    // A read that selects the register being written sees the old value.
    // The new value appears on the next read.
`endif
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side in this block sees the value from before the edge.
  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      // NOTE: the bank is small and must read back 0 after reset, so the
      // storage is built from flops with reset rather than a RAM macro.
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      rdA_data_OutBUS <= '0;
      rdB_data_OutBUS <= '0;
      carry_Out       <= 1'b0;
      zero_Out        <= 1'b0;
    end else if (!clear_InLow) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      rdA_data_OutBUS <= '0;
      rdB_data_OutBUS <= '0;
      carry_Out       <= 1'b0;
      zero_Out        <= 1'b1;
    end else begin
      rdA_data_OutBUS <= rd_a_next;
      rdB_data_OutBUS <= rd_b_next;
      if (wr_en) begin
        regs[wr_addr_In] <= new_val;
        carry_Out        <= new_carry;
        zero_Out         <= (new_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_sc_regbank_multimode.sv
// -----------------------------------------------------------------------------
// tb_sc_regbank_multimode
//   Self-checking bench for sc_regbank_multimode. It uses REGS=6, so that
//   addresses 6 and 7 exercise the out-of-range handling.
//   Checks are organised as follows:
//     - a table of directed vectors;
//     - hand-written sequences for reset, clear priority and write/read
//       collisions;
//     - randomized traffic, compared against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_sc_regbank_multimode;

  localparam int DW   = 32;
  localparam int NREG = 6;
  localparam int AW   = 3;

  logic          clk;
  logic          rst;
  logic          clear_n;
  logic          load_n;
  logic [1:0]    mode;
  logic [AW-1:0] wa;
  logic [DW-1:0] data;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          carry;
  logic          zero;

  int total = 0;
  int bad   = 0;

  sc_regbank_multimode #(.DATAWIDTH(DW), .REGS(NREG), .ADDRWIDTH(AW)) dut (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .clear_InLow                (clear_n),
    .load_InLow                 (load_n),
    .mode_In                    (mode),
    .wr_addr_In                 (wa),
    .data_InBUS                 (data),
    .rdA_addr_In                (ra),
    .rdB_addr_In                (rb),
    .rdA_data_OutBUS            (out_a),
    .rdB_data_OutBUS            (out_b),
    .carry_Out                  (carry),
    .zero_Out                   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: an array of register values plus the four output
  // registers, updated from the behavioural rules at each clock edge.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_mem [NREG];
  logic [DW-1:0] m_a;
  logic [DW-1:0] m_b;
  logic          m_c;
  logic          m_z;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_a = '0;
    m_b = '0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_read(input int addr);
    return (addr < NREG) ? m_mem[addr] : '0;
  endfunction

  task automatic model_step(input logic cn, input logic ln, input logic [1:0] md,
                            input int w, input logic [DW-1:0] d, input int a, input int b);
    logic [DW-1:0] r;
    logic [DW-1:0] nv;
    logic          nc;
    logic [DW-1:0] old_a;
    logic [DW-1:0] old_b;
    if (!cn) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_a = '0;
      m_b = '0;
      m_c = 1'b0;
      m_z = 1'b1;
      return;
    end
    old_a = model_read(a);
    old_b = model_read(b);
    if (!ln && w < NREG) begin
      r = m_mem[w];
      case (md)
        2'b00:   begin nv = d;        nc = 1'b0;              end
        2'b01:   begin nv = r + 1;    nc = (r == 32'hFFFF_FFFF); end
        2'b10:   begin nv = r << 1;   nc = r[DW-1];           end
        default: begin nv = r >> 1;   nc = r[0];              end
      endcase
      m_mem[w] = nv;
      m_c      = nc;
      m_z      = (nv == 0);
    end
`ifdef SC_REGBANK_BYPASS_EN
    m_a = model_read(a);
    m_b = model_read(b);
`else
    m_a = old_a;
    m_b = old_b;
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the model.
  // Outputs are stable #1 after the edge.
  task automatic apply(input logic cn, input logic ln, input logic [1:0] md,
                       input logic [AW-1:0] w, input logic [DW-1:0] d,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
    clear_n = cn;
    load_n  = ln;
    mode    = md;
    wa      = w;
    data    = d;
    ra      = a;
    rb      = b;
    @(posedge clk);
    model_step(cn, ln, md, int'(w), d, int'(a), int'(b));
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".a"}, out_a, m_a);
    check({tag, ".b"}, out_b, m_b);
    check({tag, ".c"}, 32'(carry), 32'(m_c));
    check({tag, ".z"}, 32'(zero), 32'(m_z));
  endtask

  typedef struct {
    logic          cn;
    logic          ln;
    logic [1:0]    md;
    logic [AW-1:0] w;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          ec;
    logic          ez;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // Directed vectors. Expected values are taken after the edge. No vector
    // reads the register written on the same edge, so the expected values do
    // not depend on the bypass option.
    //           cn    ln    md     w     d             a     b     ea            eb            ec    ez
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 3'd3, 32'hDEADBEEF, 3'd0, 3'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 3'd5, 32'h00000001, 3'd0, 3'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'b00, 3'd0, 32'h0,        3'd3, 3'd5, 32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 3'd2, 32'hFFFFFFFF, 3'd3, 3'd5, 32'hDEADBEEF, 32'h00000001, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 3'd2, 32'h0,        3'd5, 3'd3, 32'h00000001, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 3'd2, 32'h0,        3'd0, 3'd1, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 3'd0, 32'h0,        3'd2, 3'd2, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 3'd1, 32'h80000001, 3'd2, 3'd6, 32'h00000001, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 3'd1, 32'h0,        3'd3, 3'd7, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b11, 3'd1, 32'h0,        3'd0, 3'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'b00, 3'd0, 32'h0,        3'd1, 3'd2, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 3'd6, 32'h0,        3'd1, 3'd3, 32'h00000001, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 3'd0, 32'h0,        3'd1, 3'd5, 32'h00000001, 32'h00000001, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 2'b11, 3'd7, 32'h0,        3'd0, 3'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 2'b10, 3'd3, 32'h0,        3'd5, 3'd1, 32'h00000001, 32'h00000001, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 2'b00, 3'd0, 32'h0,        3'd3, 3'd4, 32'hBD5B7DDE, 32'h0,        1'b1, 1'b0};

    // Initial reset.
    rst = 1'b1; clear_n = 1'b1; load_n = 1'b1; mode = 2'b00;
    wa = '0; data = '0; ra = '0; rb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.a", out_a, 32'h0);
    check("reset.b", out_b, 32'h0);
    check("reset.c", 32'(carry), 32'h0);
    check("reset.z", 32'(zero), 32'h0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].cn, vecs[i].ln, vecs[i].md, vecs[i].w, vecs[i].d, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.a", i), out_a, vecs[i].ea);
      check($sformatf("vec%0d.b", i), out_b, vecs[i].eb);
      check($sformatf("vec%0d.c", i), 32'(carry), 32'(vecs[i].ec));
      check($sformatf("vec%0d.z", i), 32'(zero), 32'(vecs[i].ez));
    end

    // Collision: reg4 = 0x10, then write 0x20 while port A selects reg4.
    apply(1'b1, 1'b0, 2'b00, 3'd4, 32'h10, 3'd0, 3'd0);
    apply(1'b1, 1'b0, 2'b00, 3'd4, 32'h20, 3'd4, 3'd0);
`ifdef SC_REGBANK_BYPASS_EN
    check("collide.a0", out_a, 32'h20);
`else
    check("collide.a0", out_a, 32'h10);
`endif
    apply(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, 3'd4, 3'd4);
    check("collide.a1", out_a, 32'h20);
    check("collide.b1", out_b, 32'h20);

    // Clear beats load. Then three hold cycles change nothing.
    apply(1'b0, 1'b0, 2'b00, 3'd3, 32'h1234, 3'd3, 3'd4);
    check("clear.a", out_a, 32'h0);
    check("clear.b", out_b, 32'h0);
    check("clear.c", 32'(carry), 32'h0);
    check("clear.z", 32'(zero), 32'h1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 2'b00, 3'd0, 32'h1234, AW'(2 * i), AW'(2 * i + 1));
      check($sformatf("hold%0d.a", i), out_a, 32'h0);
      check($sformatf("hold%0d.b", i), out_b, 32'h0);
      check($sformatf("hold%0d.c", i), 32'(carry), 32'h0);
      check($sformatf("hold%0d.z", i), 32'(zero), 32'h1);
    end

    // Mid-cycle asynchronous reset after loading several registers.
    apply(1'b1, 1'b0, 2'b00, 3'd0, 32'hAAAA5555, 3'd0, 3'd0);
    apply(1'b1, 1'b0, 2'b01, 3'd1, 32'h0,        3'd0, 3'd0);
    apply(1'b1, 1'b0, 2'b00, 3'd5, 32'h80000000, 3'd0, 3'd1);
    check("prerst.a", out_a, 32'hAAAA5555);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst.a", out_a, 32'h0);
    check("midrst.b", out_b, 32'h0);
    check("midrst.c", 32'(carry), 32'h0);
    check("midrst.z", 32'(zero), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, AW'(2 * i), AW'(2 * i + 1));
      check($sformatf("postrst%0d.a", i), out_a, 32'h0);
      check($sformatf("postrst%0d.b", i), out_b, 32'h0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] rd;
      rd = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : DW'($urandom);
      apply(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), AW'($urandom_range(0, 7)), rd,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
